cache_rd_arbiter: RTL

//  Shares the single cache-side AXI read channel (rd_req/rd_type/rd_addr, rd_rdy, ret_*) between
//  N_MASTER caches (master 0 = icache, master 1 = dcache). Round-robin grant, one transaction in

---
 rtl/cache_rd_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/cache_rd_arbiter.sv
// Round-robin arbiter sharing one cache-side AXI read channel between N_MASTER caches.
// One transaction in flight; return beats are routed only to the granted master.
module cache_rd_arbiter #(
  parameter int unsigned N_MASTER = 2,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_MASTER-1:0]          m_rd_req,
  input  logic [3*N_MASTER-1:0]        m_rd_type,
  input  logic [ADDR_W*N_MASTER-1:0]   m_rd_addr,
  output logic [N_MASTER-1:0]          m_rd_rdy,
  output logic [N_MASTER-1:0]          m_ret_valid,
  output logic [N_MASTER-1:0]          m_ret_last,
  output logic [31:0]                  m_ret_data,
  output logic                         rd_req,
  output logic [2:0]                   rd_type,
  output logic [ADDR_W-1:0]            rd_addr,
  input  logic                         rd_rdy,
  input  logic                         ret_valid,
  input  logic                         ret_last,
  input  logic [31:0]                  ret_data,
  output logic                         proto_err
);

  localparam int unsigned PTR_W = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
  localparam logic [PTR_W:0] N_EXT = (PTR_W + 1)'(N_MASTER);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    grant_q, grant_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [2:0]          type_q, type_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          beat_cnt_q, beat_cnt_d;
  logic                proto_err_q, proto_err_d;

  logic [2*N_MASTER-1:0] req_dbl, req_rot;
  logic [PTR_W-1:0]      off;
  logic [PTR_W:0]        win_sum, nxt_sum;
  logic [PTR_W-1:0]      win, next_ptr;
  logic [3:0]            beat_num, exp_beats;
  logic                  at_expected;
  logic                  err;

  // Rotate requests so bit 0 is the master at rr_ptr; first set bit is the winner's offset.
  assign req_dbl = {m_rd_req, m_rd_req};
  assign req_rot = req_dbl >> rr_ptr_q;

  // Priority scan from rr_ptr upward (wrapping), then fold offset back to a master index.
  always_comb begin
    off = '0;
    for (int i = N_MASTER - 1; i >= 0; i--) begin
      if (req_rot[i]) off = PTR_W'(i);
    end
    win_sum = {1'b0, rr_ptr_q} + {1'b0, off};
    win     = (win_sum >= N_EXT) ? PTR_W'(win_sum - N_EXT) : PTR_W'(win_sum);
    nxt_sum = {1'b0, grant_q} + (PTR_W + 1)'(1);
    next_ptr = (nxt_sum >= N_EXT) ? PTR_W'(nxt_sum - N_EXT) : PTR_W'(nxt_sum);
  end

  // Beat accounting: a line read expects 4 beats, anything else expects 1.
  assign beat_num    = {1'b0, beat_cnt_q} + 4'd1;
  assign exp_beats   = (type_q == 3'b100) ? 4'd4 : 4'd1;
  assign at_expected = (beat_num == exp_beats);

  // Next-state logic and protocol checking.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    type_d     = type_q;
    addr_d     = addr_q;
    beat_cnt_d = beat_cnt_q;
    err        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ret_valid || rd_rdy) err = 1'b1;
        if (|m_rd_req) begin
          grant_d = win;
          type_d  = m_rd_type[3*win +: 3];
          addr_d  = m_rd_addr[ADDR_W*win +: ADDR_W];
          state_d = StReq;
        end
      end
      StReq: begin
        // A beat before acceptance is illegal, but the accept itself still goes through.
        if (ret_valid) err = 1'b1;
        if (rd_rdy) begin
          beat_cnt_d = '0;
          state_d    = StResp;
        end
      end
      StResp: begin
        if (ret_valid) begin
          if (beat_cnt_q != 3'd7) beat_cnt_d = beat_cnt_q + 3'd1;
          if (ret_last != at_expected) err = 1'b1;
          // An early last still closes the transaction.
          if (ret_last) begin
            rr_ptr_d = next_ptr;
            state_d  = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    proto_err_d = proto_err_q | err;
  end

  // State registers with synchronous reset; a reset abandons any open transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      type_q      <= '0;
      addr_q      <= '0;
      beat_cnt_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      type_q      <= type_d;
      addr_q      <= addr_d;
      beat_cnt_q  <= beat_cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign rd_req    = (state_q == StReq);
  assign rd_type   = type_q;
  assign rd_addr   = addr_q;
  assign proto_err = proto_err_q;

  // Per-master handshake routing: only the granted master sees accept and return beats.
  always_comb begin
    m_rd_rdy    = '0;
    m_ret_valid = '0;
    m_ret_last  = '0;
    m_ret_data  = '0;
    if (state_q == StReq) m_rd_rdy[grant_q] = rd_rdy;
    if (state_q == StResp) begin
      m_ret_valid[grant_q] = ret_valid;
      m_ret_last[grant_q]  = ret_last;
      m_ret_data           = ret_data;
    end
  end

endmodule
